// File: rtl/tlight_pkg.sv
// tlight_pkg: shared defaults, types and helpers for the traffic-light sequencer
package tlight_pkg;
    localparam int DEF_PIXEL_BITS = 12;
    localparam int DEF_NUM_PHASES = 3;
    localparam int COLOR_BITS = DEF_PIXEL_BITS / 3;
    localparam int PHASE_BITS = $clog2(DEF_NUM_PHASES);
    localparam int VGA_MODE_H_VISIBLE = 640;
    localparam int VGA_MODE_H_FRONT_PORCH = 16;
    localparam int VGA_MODE_H_SYNC_PULSE = 96;
    localparam int VGA_MODE_H_BACK_PORCH = 48;
    localparam int VGA_MODE_H_WHOLE_LINE = 800;
    localparam int VGA_MODE_V_VISIBLE = 480;
    localparam int VGA_MODE_V_FRONT_PORCH = 10;
    localparam int VGA_MODE_V_SYNC_PULSE = 2;
    localparam int VGA_MODE_V_BACK_PORCH = 33;
    localparam int VGA_MODE_V_WHOLE_FRAME = 525;

    typedef logic [DEF_PIXEL_BITS-1:0] pixel_t;

    function automatic int phase_next(int phase, int num_phases);
        return (phase == num_phases - 1) ? 0 : phase + 1;
    endfunction
endpackage

// File: rtl/tlight_phase_ctl.sv
// tlight_phase_ctl: frame-counted phase sequencing with early exit and pause
module tlight_phase_ctl import tlight_pkg::*; #(
    parameter int NUM_PHASES = DEF_NUM_PHASES,
    parameter int FRAME_CNT_BITS = 10,
    parameter int REQ_PHASE = 2,
    parameter int MIN_FRAMES = 4,
    localparam int PB = $clog2(NUM_PHASES)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      frame_tick,
    input  logic                      pause,
    input  logic                      req,
    input  logic [FRAME_CNT_BITS-1:0] dur,
    output logic [PB-1:0]             phase,
    output logic                      phase_start,
    output logic                      req_pending
);
    logic [FRAME_CNT_BITS-1:0] frame_cnt, frame_cnt_nx;
    logic [FRAME_CNT_BITS:0]   cnt_inc, dur_eff;
    logic [PB-1:0]             phase_nx;
    logic                      phase_end, pending_nx, advance;

    // end-of-phase decision; one extra bit keeps frame_cnt+1 from wrapping
    always_comb begin
        advance = frame_tick && !pause;
        dur_eff = (dur == '0) ? (FRAME_CNT_BITS+1)'(1) : {1'b0, dur};
        cnt_inc = {1'b0, frame_cnt} + 1'b1;
        phase_end = advance && (cnt_inc >= dur_eff ||
                    (int'(phase) == REQ_PHASE && req_pending && int'(cnt_inc) >= MIN_FRAMES));
        phase_nx = phase_end ? PB'(phase_next(int'(phase), NUM_PHASES)) : phase;
        frame_cnt_nx = phase_end ? '0 : (advance && !(&frame_cnt)) ? frame_cnt + 1'b1 : frame_cnt;
        pending_nx = req || (req_pending && !(phase_end && int'(phase) == REQ_PHASE));
    end

    // phase state register; a new request wins over the clear on leaving REQ_PHASE
    always_ff @(posedge clk) begin
        if (reset) begin
            phase <= '0;
            frame_cnt <= '0;
            phase_start <= 1'b0;
            req_pending <= 1'b0;
        end else begin
            phase <= phase_nx;
            frame_cnt <= frame_cnt_nx;
            phase_start <= phase_end;
            req_pending <= pending_nx;
        end
    end
endmodule

// File: rtl/vga_sync.sv
// vga_sync: pixel/line counters with active-low sync and visible-area flag
module vga_sync import tlight_pkg::*; #(
    parameter int H_VISIBLE = VGA_MODE_H_VISIBLE,
    parameter int H_FRONT_PORCH = VGA_MODE_H_FRONT_PORCH,
    parameter int H_SYNC_PULSE = VGA_MODE_H_SYNC_PULSE,
    parameter int H_BACK_PORCH = VGA_MODE_H_BACK_PORCH,
    parameter int H_WHOLE_LINE = VGA_MODE_H_WHOLE_LINE,
    parameter int V_VISIBLE = VGA_MODE_V_VISIBLE,
    parameter int V_FRONT_PORCH = VGA_MODE_V_FRONT_PORCH,
    parameter int V_SYNC_PULSE = VGA_MODE_V_SYNC_PULSE,
    parameter int V_BACK_PORCH = VGA_MODE_V_BACK_PORCH,
    parameter int V_WHOLE_FRAME = VGA_MODE_V_WHOLE_FRAME,
    localparam int XW = $clog2(H_WHOLE_LINE),
    localparam int YW = $clog2(V_WHOLE_FRAME)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          hsync,
    output logic          vsync,
    output logic          visible
);
    localparam int H_LAST = H_VISIBLE + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH - 1;
    localparam int V_LAST = V_VISIBLE + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH - 1;

    // raster position: x wraps each line, y advances on x wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            x <= '0;
            y <= '0;
        end else if (inc) begin
            x <= (int'(x) == H_LAST) ? '0 : x + 1'b1;
            if (int'(x) == H_LAST)
                y <= (int'(y) == V_LAST) ? '0 : y + 1'b1;
        end
    end

    // sync pulses sit after the front porch; visible is the top-left active area
    always_comb begin
        hsync = !(int'(x) >= H_VISIBLE + H_FRONT_PORCH && int'(x) < H_VISIBLE + H_FRONT_PORCH + H_SYNC_PULSE);
        vsync = !(int'(y) >= V_VISIBLE + V_FRONT_PORCH && int'(y) < V_VISIBLE + V_FRONT_PORCH + V_SYNC_PULSE);
        visible = int'(x) < H_VISIBLE && int'(y) < V_VISIBLE;
    end
endmodule

// File: rtl/tlight_seq.sv
// tlight_seq: multi-phase full-screen VGA traffic-light sequencer
module tlight_seq import tlight_pkg::*; #(
    parameter int PIXEL_BITS = DEF_PIXEL_BITS,
    parameter int NUM_PHASES = DEF_NUM_PHASES,
    parameter int FRAME_CNT_BITS = 10,
    parameter int REQ_PHASE = 2,
    parameter int MIN_FRAMES = 4,
    parameter int H_VISIBLE = VGA_MODE_H_VISIBLE,
    parameter int H_FRONT_PORCH = VGA_MODE_H_FRONT_PORCH,
    parameter int H_SYNC_PULSE = VGA_MODE_H_SYNC_PULSE,
    parameter int H_BACK_PORCH = VGA_MODE_H_BACK_PORCH,
    parameter int H_WHOLE_LINE = VGA_MODE_H_WHOLE_LINE,
    parameter int V_VISIBLE = VGA_MODE_V_VISIBLE,
    parameter int V_FRONT_PORCH = VGA_MODE_V_FRONT_PORCH,
    parameter int V_SYNC_PULSE = VGA_MODE_V_SYNC_PULSE,
    parameter int V_BACK_PORCH = VGA_MODE_V_BACK_PORCH,
    parameter int V_WHOLE_FRAME = VGA_MODE_V_WHOLE_FRAME,
    localparam int CB = PIXEL_BITS / 3,
    localparam int PB = $clog2(NUM_PHASES)
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_PHASES*PIXEL_BITS-1:0]     phase_color,
    input  logic [NUM_PHASES*FRAME_CNT_BITS-1:0] phase_frames,
    input  logic                                 req,
    input  logic                                 pause,
    output logic [CB-1:0]                        vga_red,
    output logic [CB-1:0]                        vga_grn,
    output logic [CB-1:0]                        vga_blu,
    output logic                                 vga_hsync,
    output logic                                 vga_vsync,
    output logic [PB-1:0]                        phase,
    output logic                                 phase_start,
    output logic                                 req_pending
);
    localparam int XW = $clog2(H_WHOLE_LINE);
    localparam int YW = $clog2(V_WHOLE_FRAME);

    logic [XW-1:0]             x;
    logic [YW-1:0]             y;
    logic                      hsync, vsync, visible, frame_tick;
    logic [FRAME_CNT_BITS-1:0] dur;
    logic [PIXEL_BITS-1:0]     pix;

    vga_sync #(
        .H_VISIBLE(H_VISIBLE), .H_FRONT_PORCH(H_FRONT_PORCH), .H_SYNC_PULSE(H_SYNC_PULSE),
        .H_BACK_PORCH(H_BACK_PORCH), .H_WHOLE_LINE(H_WHOLE_LINE),
        .V_VISIBLE(V_VISIBLE), .V_FRONT_PORCH(V_FRONT_PORCH), .V_SYNC_PULSE(V_SYNC_PULSE),
        .V_BACK_PORCH(V_BACK_PORCH), .V_WHOLE_FRAME(V_WHOLE_FRAME)
    ) u_sync (
        .clk(clk), .reset(reset), .inc(1'b1), .x(x), .y(y),
        .hsync(hsync), .vsync(vsync), .visible(visible)
    );

    tlight_phase_ctl #(
        .NUM_PHASES(NUM_PHASES), .FRAME_CNT_BITS(FRAME_CNT_BITS),
        .REQ_PHASE(REQ_PHASE), .MIN_FRAMES(MIN_FRAMES)
    ) u_ctl (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .pause(pause), .req(req),
        .dur(dur), .phase(phase), .phase_start(phase_start), .req_pending(req_pending)
    );

    // frame start marker plus live per-phase duration and colour selection
    always_comb begin
        frame_tick = x == '0 && y == '0;
        dur = phase_frames[int'(phase)*FRAME_CNT_BITS +: FRAME_CNT_BITS];
        pix = phase_color[int'(phase)*PIXEL_BITS +: PIXEL_BITS];
    end

    // output stage: colour blanked outside the visible area, sync delayed to match
    always_ff @(posedge clk) begin
        if (reset) begin
            vga_red <= '0;
            vga_grn <= '0;
            vga_blu <= '0;
            vga_hsync <= 1'b1;
            vga_vsync <= 1'b1;
        end else begin
            vga_red <= visible ? pix[PIXEL_BITS-1 -: CB] : '0;
            vga_grn <= visible ? pix[2*CB-1 -: CB] : '0;
            vga_blu <= visible ? pix[CB-1:0] : '0;
            vga_hsync <= hsync;
            vga_vsync <= vsync;
        end
    end
endmodule

// File: tb/tb_tlight_seq.sv
// tb_tlight_seq: scoreboard bench for the traffic-light sequencer in a tiny video mode
module tb_tlight_seq;
    import tlight_pkg::*;

    logic clk = 1'b0, reset = 1'b1, req = 1'b0, pause = 1'b0;
    pixel_t col [3];
    logic [9:0] frm [3];
    logic [35:0] phase_color;
    logic [29:0] phase_frames;
    logic [3:0] vga_red, vga_grn, vga_blu;
    logic vga_hsync, vga_vsync, phase_start, req_pending;
    logic [1:0] phase;

    typedef struct {
        int r, g, b, hs, vs, ph, st, pend;
    } exp_t;

    exp_t q[$];
    int errors = 0, checks = 0;
    int mx, my, mph, mcnt, mpend;

    assign phase_color = {col[2], col[1], col[0]};
    assign phase_frames = {frm[2], frm[1], frm[0]};

    always #5 clk = ~clk;

    tlight_seq #(
        .PIXEL_BITS(12), .NUM_PHASES(3), .FRAME_CNT_BITS(10), .REQ_PHASE(2), .MIN_FRAMES(4),
        .H_VISIBLE(8), .H_FRONT_PORCH(1), .H_SYNC_PULSE(1), .H_BACK_PORCH(2), .H_WHOLE_LINE(12),
        .V_VISIBLE(4), .V_FRONT_PORCH(1), .V_SYNC_PULSE(1), .V_BACK_PORCH(1), .V_WHOLE_FRAME(7)
    ) dut (
        .clk(clk), .reset(reset), .phase_color(phase_color), .phase_frames(phase_frames),
        .req(req), .pause(pause), .vga_red(vga_red), .vga_grn(vga_grn), .vga_blu(vga_blu),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .phase(phase),
        .phase_start(phase_start), .req_pending(req_pending)
    );

    task automatic check(string tag, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // behavioural model: predicts outputs after the coming edge, pushes them, then clocks
    task automatic step();
        exp_t e;
        int dur;
        logic tick, vis, fin;
        pixel_t pix;
        if (reset) begin
            mx = 0; my = 0; mph = 0; mcnt = 0; mpend = 0;
            e = '{0, 0, 0, 1, 1, 0, 0, 0};
        end else begin
            tick = mx == 0 && my == 0;
            vis = mx < 8 && my < 4;
            pix = vis ? col[mph] : 12'h000;
            e.r = int'(pix[11:8]);
            e.g = int'(pix[7:4]);
            e.b = int'(pix[3:0]);
            e.hs = (mx == 9) ? 0 : 1;
            e.vs = (my == 5) ? 0 : 1;
            dur = (frm[mph] == 0) ? 1 : int'(frm[mph]);
            fin = tick && !pause && (mcnt + 1 >= dur || (mph == 2 && mpend == 1 && mcnt + 1 >= 4));
            e.st = fin ? 1 : 0;
            mpend = req ? 1 : (fin && mph == 2) ? 0 : mpend;
            if (fin) begin
                mph = (mph == 2) ? 0 : mph + 1;
                mcnt = 0;
            end else if (tick && !pause && mcnt != 1023) begin
                mcnt++;
            end
            e.ph = mph;
            e.pend = mpend;
            mx = (mx == 11) ? 0 : mx + 1;
            if (mx == 0) my = (my == 6) ? 0 : my + 1;
        end
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic run(int n);
        repeat (n) step();
    endtask

    task automatic restart(int f0, int f1, int f2);
        frm[0] = 10'(f0);
        frm[1] = 10'(f1);
        frm[2] = 10'(f2);
        req = 1'b0;
        pause = 1'b0;
        reset = 1'b1;
        run(2);
        reset = 1'b0;
    endtask

    // scoreboard: compare every predicted cycle on the falling edge
    always @(negedge clk) begin : sb
        exp_t e;
        if (q.size() != 0) begin
            e = q.pop_front();
            check("red", int'(vga_red), e.r);
            check("grn", int'(vga_grn), e.g);
            check("blu", int'(vga_blu), e.b);
            check("hsync", int'(vga_hsync), e.hs);
            check("vsync", int'(vga_vsync), e.vs);
            check("phase", int'(phase), e.ph);
            check("phase_start", int'(phase_start), e.st);
            check("req_pending", int'(req_pending), e.pend);
        end
    end

    initial begin
        int cnt;
        col[0] = 12'hF00;
        col[1] = 12'hFF0;
        col[2] = 12'h0F0;

        // basic sequencing with durations {2,1,3}
        restart(2, 1, 3);
        check("rst_red", int'(vga_red), 0);
        check("rst_hsync", int'(vga_hsync), 1);
        run(84);
        check("seq_p0_hold", int'(phase), 0);
        step();
        check("seq_p1", int'(phase), 1);
        check("seq_start", int'(phase_start), 1);
        step();
        check("seq_start_clr", int'(phase_start), 0);
        run(83);
        check("seq_p2", int'(phase), 2);
        run(252);
        check("seq_wrap", int'(phase), 0);
        run(2);
        check("vis_red", int'(vga_red), 15);
        check("vis_grn", int'(vga_grn), 0);
        check("vis_blu", int'(vga_blu), 0);
        run(7);
        check("blank_red", int'(vga_red), 0);
        check("blank_hsync", int'(vga_hsync), 0);
        cnt = 0;
        repeat (504) begin
            step();
            if (phase_start) cnt++;
        end
        check("start_pulses", cnt, 3);

        // early exit: request latched in phase 0 cuts phase 2 to MIN_FRAMES
        restart(2, 1, 20);
        run(9);
        req = 1'b1;
        step();
        req = 1'b0;
        check("early_pend", int'(req_pending), 1);
        run(494);
        check("early_p2", int'(phase), 2);
        check("early_pend_hold", int'(req_pending), 1);
        step();
        check("early_end", int'(phase), 0);
        check("early_pend_clr", int'(req_pending), 0);

        // request coinciding with the clear stays pending for the next visit
        restart(2, 1, 20);
        run(9);
        req = 1'b1;
        step();
        req = 1'b0;
        run(494);
        req = 1'b1;
        step();
        req = 1'b0;
        check("race_end", int'(phase), 0);
        check("race_pend", int'(req_pending), 1);
        run(587);
        check("race_p2", int'(phase), 2);
        step();
        check("race_end2", int'(phase), 0);
        check("race_pend_clr", int'(req_pending), 0);

        // zero duration counts as one frame; pause freezes the phase for five frames
        restart(2, 0, 3);
        run(168);
        check("zero_p1", int'(phase), 1);
        step();
        check("zero_p2", int'(phase), 2);
        run(31);
        pause = 1'b1;
        cnt = 0;
        repeat (420) begin
            step();
            if (!vga_vsync) cnt++;
        end
        check("pause_vsync", cnt, 60);
        check("pause_p2", int'(phase), 2);
        pause = 1'b0;
        run(220);
        check("pause_resume_hold", int'(phase), 2);
        step();
        check("pause_resume_end", int'(phase), 0);

        // reset mid-frame returns every output to its reset value
        req = 1'b1;
        step();
        req = 1'b0;
        run(20);
        reset = 1'b1;
        step();
        check("mid_rst_red", int'(vga_red), 0);
        check("mid_rst_hsync", int'(vga_hsync), 1);
        check("mid_rst_vsync", int'(vga_vsync), 1);
        check("mid_rst_phase", int'(phase), 0);
        check("mid_rst_start", int'(phase_start), 0);
        check("mid_rst_pend", int'(req_pending), 0);
        reset = 1'b0;
        run(84);
        check("post_rst_p0", int'(phase), 0);
        step();
        check("post_rst_p1", int'(phase), 1);

        @(negedge clk);
        #1;
        check("drain", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
